// File: rtl/muldiv_unit_pkg.sv
// Shared types for the multi-cycle multiply/divide unit and its decode helpers.
package muldiv_unit_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned MDU_ITER = XLEN;

    typedef logic [XLEN-1:0] dtype_t;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_LUI,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHU,
        ALU_DIV,
        ALU_MOD,
        ALU_DIVU,
        ALU_MODU
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_CALC,
        MDU_DONE
    } mdu_state_e;

    // Op state captured on accept; operands live separately in the datapath.
    typedef struct packed {
        alu_ctrl_e op;
        logic      neg;       // negate the selected result half on completion
        logic      div_zero;  // divisor was zero
    } mdu_ctl_t;

    // True for ops that must be routed to the multi-cycle unit.
    function automatic logic is_muldiv(input alu_ctrl_e op);
        case (op)
            ALU_MUL, ALU_MULH, ALU_MULHU,
            ALU_DIV, ALU_MOD, ALU_DIVU, ALU_MODU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // Ops that work on magnitudes and need a sign fixup at the end.
    function automatic logic is_signed_md(input alu_ctrl_e op);
        case (op)
            ALU_MUL, ALU_MULH, ALU_DIV, ALU_MOD: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // Ops that use the restoring-divide step rather than shift-add.
    function automatic logic is_div_op(input alu_ctrl_e op);
        case (op)
            ALU_DIV, ALU_MOD, ALU_DIVU, ALU_MODU: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response handshake bundle between the execute stage and the mul/div unit.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
) ();
    import muldiv_unit_pkg::*;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    alu_ctrl_e        aluctrl;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output flush, in_valid, aluctrl, src1, src2, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  flush, in_valid, aluctrl, src1, src2, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/muldiv_unit_core.sv
// One iteration of the shift-add multiply or restoring divide over a 2*WIDTH accumulator.
// Multiply: acc = {partial_hi, multiplier_remaining}; divide: acc = {remainder, quotient/dividend}.
module muldiv_unit_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next_c
);

    localparam int unsigned AW = 2 * WIDTH;

    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] rem_sub;

    // Single step: add-then-shift-right for multiply, shift-left-then-trial-subtract for divide.
    always_comb begin
        msum    = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh  = acc[AW-1:WIDTH-1];
        ge      = (rem_sh >= {1'b0, opnd});
        rem_sub = WIDTH'(rem_sh - {1'b0, opnd});
        if (is_div) begin
            acc_next_c = ge ? {rem_sub,           acc[WIDTH-2:0], 1'b1}
                            : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next_c = {msum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle mul/div sequencer: accept, WIDTH iterations, sign fixup, hold result until taken.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_ITER
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);

    localparam int unsigned AW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    mdu_state_e       state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [AW-1:0]    acc_q,    acc_d;
    logic [WIDTH-1:0] opnd_q,   opnd_d;
    mdu_ctl_t         ctl_q,    ctl_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             in_ready_q, out_valid_q, busy_q;

    logic [AW-1:0]    acc_step_c;
    logic             s1_neg_c, s2_neg_c, sgn_c;
    logic [WIDTH-1:0] abs1_c, abs2_c;
    logic [AW-1:0]    prod_c;
    logic [WIDTH-1:0] quot_c, rem_c, fix_c;

    muldiv_unit_core #(.WIDTH(WIDTH)) u_core (
        .is_div     (is_div_op(ctl_q.op)),
        .acc        (acc_q),
        .opnd       (opnd_q),
        .acc_next_c (acc_step_c)
    );

    // Magnitudes and sign bits of the incoming operands, used only on the accept edge.
    always_comb begin
        sgn_c    = is_signed_md(bus.aluctrl);
        s1_neg_c = sgn_c && bus.src1[WIDTH-1];
        s2_neg_c = sgn_c && bus.src2[WIDTH-1];
        abs1_c   = s1_neg_c ? -bus.src1 : bus.src1;
        abs2_c   = s2_neg_c ? -bus.src2 : bus.src2;
    end

    // Final result from the accumulator: negate the relevant half, then pick by op.
    // Signed overflow and mod-by-zero come out of the datapath naturally.
    always_comb begin
        prod_c = ctl_q.neg ? -acc_q             : acc_q;
        quot_c = ctl_q.neg ? -acc_q[WIDTH-1:0]  : acc_q[WIDTH-1:0];
        rem_c  = ctl_q.neg ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];
        case (ctl_q.op)
            ALU_MUL:             fix_c = prod_c[WIDTH-1:0];
            ALU_MULH, ALU_MULHU: fix_c = prod_c[AW-1:WIDTH];
            ALU_DIV, ALU_DIVU:   fix_c = ctl_q.div_zero ? '1 : quot_c;
            ALU_MOD, ALU_MODU:   fix_c = rem_c;
            default:             fix_c = '0;
        endcase
    end

    // Next-state and datapath update; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        ctl_d    = ctl_q;
        result_d = result_q;
        if (bus.flush) begin
            state_d = MDU_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (bus.in_valid) begin
                        state_d        = MDU_CALC;
                        cnt_d          = CW'(WIDTH);
                        acc_d          = {{WIDTH{1'b0}}, abs1_c};
                        opnd_d         = abs2_c;
                        ctl_d.op       = is_muldiv(bus.aluctrl) ? bus.aluctrl : ALU_ADD;
                        ctl_d.neg      = (bus.aluctrl == ALU_MOD) ? s1_neg_c : (s1_neg_c ^ s2_neg_c);
                        ctl_d.div_zero = (bus.src2 == '0);
                    end
                end
                MDU_CALC: begin
                    // cnt counts iterations still to run; the cycle at zero applies the fixup
                    if (cnt_q == '0) begin
                        state_d  = MDU_DONE;
                        result_d = fix_c;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                        acc_d = acc_step_c;
                    end
                end
                MDU_DONE: begin
                    if (bus.out_ready) begin
                        state_d = MDU_IDLE;
                    end
                end
                default: begin
                    state_d = MDU_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MDU_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            ctl_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            ctl_q       <= ctl_d;
            result_q    <= result_d;
            in_ready_q  <= (state_d == MDU_IDLE);
            out_valid_q <= (state_d == MDU_DONE);
            busy_q      <= (state_d != MDU_IDLE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;

endmodule
